sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO built on a register-array memory. It replaces the separate memory plus external pointer logic used in single-clock datapaths. It provides:
- full/empty and programmable almost-full/almost-empty flags;
- a fill count;
- sticky overflow/underflow error flags;
- a selectable read mode: registered read, or first-word-fall-through (FWFT).

## Interface
Parameters:
- DATASIZE, 8, data word width in bits
- ADDRSIZE, 4, address width; DEPTH = 1 << ADDRSIZE
- AFULL_THRESH, DEPTH-2, walmost_full asserts when count >= this value; legal range 1..DEPTH
- AEMPTY_THRESH, 2, ralmost_empty asserts when count <= this value; legal range 0..DEPTH-1
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  reset, synchronous and active-low
- winc  in  1  write request
- wdata  in  DATASIZE  write data
- rinc  in  1  read (pop) request
- rdata  out  DATASIZE  read data
- wfull  out  1  FIFO holds DEPTH words
- rempty  out  1  FIFO holds 0 words
- walmost_full  out  1  count >= AFULL_THRESH
- ralmost_empty  out  1  count <= AEMPTY_THRESH
- count  out  ADDRSIZE+1  number of stored words, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty

## Operation
- Write accept: we = winc && !wfull. On accept, mem[wptr] <= wdata and wptr increments.
- Read accept: re = rinc && !rempty. On accept, rptr increments.
- Both decisions use the flag values registered before the edge.
- Pointers are ADDRSIZE+1 bits wide; the MSB is the wrap bit and the low ADDRSIZE bits address the memory. Pointers wrap modulo 2*DEPTH.
- count_next = count + we - re. It never goes below 0 or above DEPTH.
- All flags are registered and computed from count_next, so they change on the same edge as count:
  - rempty = (count_next == 0)
  - wfull = (count_next == DEPTH)
  - walmost_full = (count_next >= AFULL_THRESH)
  - ralmost_empty = (count_next <= AEMPTY_THRESH)
- Write and read in the same cycle while 0 < count < DEPTH: both are accepted and count is unchanged.
- Read while empty (even with a simultaneous write): the read is rejected and underflow is set. The write is accepted.
- Write while full (even with a simultaneous read): the write is rejected and overflow is set. The read is accepted, so count becomes DEPTH-1.
- overflow and underflow stay at 1 until reset.
- FWFT=0: rdata is a register loaded with mem[rptr] on a read accept. It holds its value otherwise.
- FWFT=1: rdata = mem[rptr] combinationally. It is valid whenever rempty=0 and is don't-care while rempty=1. rinc pops the displayed word.
- Memory contents are not reset.

## Timing
- Reset (rst_n=0 sampled at an edge): after that edge, wptr=rptr=0, count=0, rempty=1, wfull=0, walmost_full=0, ralmost_empty=1, overflow=0, underflow=0. In FWFT=0 mode, rdata=0.
- Reset mid-operation: stored data is abandoned. winc and rinc sampled in the reset cycle are ignored and raise no error flags.
- Write latency: a word written at edge k is visible as rempty=0 after edge k.
  - FWFT=1: rdata shows that word after edge k.
  - FWFT=0: rinc sampled at edge k+1 puts the word on rdata after edge k+1, i.e. 1-cycle read latency.
- Throughput: one write and one read per cycle sustained. There are no bubbles at pointer wrap.

## Structure
- Shared package fifo_pkg holds:
  - the count width function clog2-style helper;
  - parameter-legality checks (AFULL_THRESH range, AEMPTY_THRESH range, FWFT in {0,1}) as elaboration-time assertions.
- Sub-module sync_fifo_mem: DEPTH x DATASIZE register array with one write port and one read port, write gated by we. Its read path is selected by a FWFT parameter: combinational output, or output registered on re.
- The top level holds pointers, count, flags and error logic.

## Test plan
Default parameters unless noted.
- Reset: hold rst_n=0 for 2 cycles with winc=rinc=1. Required: count=0, rempty=1, ralmost_empty=1, wfull=0, overflow=underflow=0, rdata=0.
- Fill and drain: write 0x00..0x0F on 16 consecutive cycles. Required: wfull=1 after the 16th edge and walmost_full=1 from count=14.
  - A 17th winc with 0xFF sets overflow and does not change count.
  - 16 reads then return 0x00..0x0F in order, each one cycle after its rinc, and rempty=1 after the last.
- Concurrent traffic across wrap: preload 5 words, then run winc=rinc=1 for 40 cycles with incrementing data. Required: count stays at 5, output order is exact, and flags stay constant through two pointer wraps.
- Boundary collisions:
  - At count=0, winc=rinc=1: underflow is set and count becomes 1.
  - At count=16, winc=rinc=1: overflow is set, count becomes 15, and the popped word is correct.
- FWFT=1, AFULL_THRESH=12, AEMPTY_THRESH=2:
  - Write 0xA5 into the empty FIFO. Required: rempty=0 and rdata=0xA5 after the same edge, with no rinc needed.
  - walmost_full asserts on the edge where count reaches 12.
  - ralmost_empty deasserts on the edge where count reaches 3.
- Reset mid-run: at count=7, assert rst_n=0 for one cycle together with winc=1. Required: all reset values appear after that edge, and a subsequent write and read returns the new data only.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO: width calculation and parameter legality.
package fifo_pkg;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      for (int i = 0; i < 32; i++) begin
         if (v > 0) begin
            result = result + 1;
            v      = v >> 1;
         end
      end
      return result;
   endfunction

   function automatic bit params_legal(input int addrsize, input int afull_thresh,
                                       input int aempty_thresh, input int fwft);
      int depth;
      depth = 1 << addrsize;
      return (afull_thresh >= 1) && (afull_thresh <= depth) &&
             (aempty_thresh >= 0) && (aempty_thresh <= depth - 1) &&
             ((fwft == 0) || (fwft == 1));
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Register-array storage with one write port and one read port; the read path is
// either combinational (first-word-fall-through) or a register loaded on re.
module sync_fifo_mem #(
   parameter int DATASIZE = 8,
   parameter int ADDRSIZE = 4,
   parameter int FWFT     = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we,
   input  logic [ADDRSIZE-1:0] waddr,
   input  logic [DATASIZE-1:0] wdata,
   input  logic                re,
   input  logic [ADDRSIZE-1:0] raddr,
   output logic [DATASIZE-1:0] rdata
);

   localparam int DEPTH = 1 << ADDRSIZE;

   logic [DATASIZE-1:0] mem_q [DEPTH];

   // Contents are deliberately never cleared; pointers alone define validity.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         logic unused_fwft;
         assign unused_fwft = ^{rst_n, re};
         assign rdata       = mem_q[raddr];
      end else begin : g_registered
         logic [DATASIZE-1:0] rdata_q;
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               rdata_q <= '0;
            end else if (re) begin
               rdata_q <= mem_q[raddr];
            end
         end
         assign rdata = rdata_q;
      end
   endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, fill count, registered status flags and sticky error
// flags around a register-array memory.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATASIZE      = 8,
   parameter int ADDRSIZE      = 4,
   parameter int AFULL_THRESH  = (1 << ADDRSIZE) - 2,
   parameter int AEMPTY_THRESH = 2,
   parameter int FWFT          = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                winc,
   input  logic [DATASIZE-1:0] wdata,
   input  logic                rinc,
   output logic [DATASIZE-1:0] rdata,
   output logic                wfull,
   output logic                rempty,
   output logic                walmost_full,
   output logic                ralmost_empty,
   output logic [ADDRSIZE:0]   count,
   output logic                overflow,
   output logic                underflow
);

   localparam int DEPTH = 1 << ADDRSIZE;
   localparam int CW    = clog2(DEPTH + 1);

   generate
      if (!params_legal(ADDRSIZE, AFULL_THRESH, AEMPTY_THRESH, FWFT)) begin : g_illegal_params
         $error("sync_fifo: illegal threshold or FWFT parameter");
      end
   endgenerate

   logic [ADDRSIZE:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              wfull_q, wfull_d, rempty_q, rempty_d;
   logic              afull_q, afull_d, aempty_q, aempty_d;
   logic              overflow_q, overflow_d, underflow_q, underflow_d;
   logic              we, re;

   // Requests sampled during reset must neither move state nor raise errors.
   assign we = winc & ~wfull_q & rst_n;
   assign re = rinc & ~rempty_q & rst_n;

   always_comb begin
      wptr_d      = wptr_q + {{ADDRSIZE{1'b0}}, we};
      rptr_d      = rptr_q + {{ADDRSIZE{1'b0}}, re};
      count_d     = count_q + {{(CW-1){1'b0}}, we} - {{(CW-1){1'b0}}, re};
      rempty_d    = (count_d == '0);
      wfull_d     = (count_d == CW'(DEPTH));
      afull_d     = (count_d >= CW'(AFULL_THRESH));
      aempty_d    = (count_d <= CW'(AEMPTY_THRESH));
      overflow_d  = overflow_q | (winc & wfull_q);
      underflow_d = underflow_q | (rinc & rempty_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         rempty_q    <= 1'b1;
         wfull_q     <= 1'b0;
         afull_q     <= 1'b0;
         aempty_q    <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         rempty_q    <= rempty_d;
         wfull_q     <= wfull_d;
         afull_q     <= afull_d;
         aempty_q    <= aempty_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   sync_fifo_mem #(
      .DATASIZE (DATASIZE),
      .ADDRSIZE (ADDRSIZE),
      .FWFT     (FWFT)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .waddr (wptr_q[ADDRSIZE-1:0]),
      .wdata (wdata),
      .re    (re),
      .raddr (rptr_q[ADDRSIZE-1:0]),
      .rdata (rdata)
   );

   assign count         = count_q;
   assign wfull         = wfull_q;
   assign rempty        = rempty_q;
   assign walmost_full  = afull_q;
   assign ralmost_empty = aempty_q;
   assign overflow      = overflow_q;
   assign underflow     = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Drives a registered-read FIFO and an FWFT FIFO with identical traffic and checks
// both against a queue-based model of the FIFO contract.
module tb_sync_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       winc, rinc;
   logic [7:0] wdata;

   logic [7:0] rdata0, rdata1;
   logic       wfull0, rempty0, afull0, aempty0, ovf0, unf0;
   logic       wfull1, rempty1, afull1, aempty1, ovf1, unf1;
   logic [4:0] count0, count1;

   always #5 clk = ~clk;

   sync_fifo dut_reg (
      .clk (clk), .rst_n (rst_n), .winc (winc), .wdata (wdata), .rinc (rinc),
      .rdata (rdata0), .wfull (wfull0), .rempty (rempty0), .walmost_full (afull0),
      .ralmost_empty (aempty0), .count (count0), .overflow (ovf0), .underflow (unf0)
   );

   sync_fifo #(.AFULL_THRESH (12), .AEMPTY_THRESH (2), .FWFT (1)) dut_fwft (
      .clk (clk), .rst_n (rst_n), .winc (winc), .wdata (wdata), .rinc (rinc),
      .rdata (rdata1), .wfull (wfull1), .rempty (rempty1), .walmost_full (afull1),
      .ralmost_empty (aempty1), .count (count1), .overflow (ovf1), .underflow (unf1)
   );

   logic [7:0] q[$];
   bit         ovf_m, unf_m;
   logic [7:0] rd_m;
   int         total = 0;
   int         bad   = 0;
   int         txn   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL txn=%0d %s got=%0h exp=%0h", txn, tag, got, exp);
      end
   endtask

   task automatic compare_all();
      int n;
      n = q.size();
      chk("count0",  count0,  n);
      chk("rempty0", rempty0, n == 0);
      chk("wfull0",  wfull0,  n == 16);
      chk("afull0",  afull0,  n >= 14);
      chk("aempty0", aempty0, n <= 2);
      chk("ovf0",    ovf0,    ovf_m);
      chk("unf0",    unf0,    unf_m);
      chk("rdata0",  rdata0,  rd_m);
      chk("count1",  count1,  n);
      chk("rempty1", rempty1, n == 0);
      chk("wfull1",  wfull1,  n == 16);
      chk("afull1",  afull1,  n >= 12);
      chk("aempty1", aempty1, n <= 2);
      chk("ovf1",    ovf1,    ovf_m);
      chk("unf1",    unf1,    unf_m);
      if (n > 0) chk("rdata1", rdata1, q[0]);
   endtask

   task automatic step(input bit w, input bit r, input logic [7:0] d);
      bit full, empty;
      winc  = w;
      rinc  = r;
      wdata = d;
      @(posedge clk);
      full  = (q.size() == 16);
      empty = (q.size() == 0);
      if (w && full)  ovf_m = 1'b1;
      if (r && empty) unf_m = 1'b1;
      if (r && !empty) rd_m = q.pop_front();
      if (w && !full)  q.push_back(d);
      @(negedge clk);
      txn++;
      $display("txn %0d w=%0b r=%0b d=%02h count=%0d", txn, w, r, d, q.size());
      compare_all();
   endtask

   task automatic reset_cycles(input int n, input bit w, input bit r);
      rst_n = 1'b0;
      winc  = w;
      rinc  = r;
      wdata = 8'h5A;
      repeat (n) @(posedge clk);
      q.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
      rd_m  = 8'h00;
      @(negedge clk);
      txn++;
      $display("txn %0d reset cycles=%0d w=%0b r=%0b", txn, n, w, r);
      compare_all();
      rst_n = 1'b1;
      winc  = 1'b0;
      rinc  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      winc  = 1'b0;
      rinc  = 1'b0;
      wdata = 8'h00;
      ovf_m = 1'b0;
      unf_m = 1'b0;
      rd_m  = 8'h00;
      @(negedge clk);

      reset_cycles(2, 1'b1, 1'b1);

      // Fill, overflow attempt, drain.
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i));
      step(1'b1, 1'b0, 8'hFF);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);

      // Sustained concurrent traffic across two pointer wraps.
      reset_cycles(1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++)  step(1'b1, 1'b0, 8'(8'h40 + i));
      for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'(8'h50 + i));
      for (int i = 0; i < 5; i++)  step(1'b0, 1'b1, 8'h00);

      // Collisions at empty and at full.
      step(1'b1, 1'b1, 8'hC0);
      for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 8'(8'hC1 + i));
      step(1'b1, 1'b1, 8'hEE);

      // FWFT fall-through on an empty FIFO, then a reset at count 7 with a write pending.
      reset_cycles(1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'hA5);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
      reset_cycles(1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 8'h77);
      step(1'b0, 1'b1, 8'h00);

      // Random traffic with phases biased toward filling and toward draining.
      reset_cycles(1, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) begin
         int wp;
         wp = (i < 100) ? 75 : ((i < 200) ? 25 : 50);
         step($urandom_range(99) < wp, $urandom_range(99) < (100 - wp), 8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
